// File: rtl/cordic_vec_arb_pkg.sv
// Shared types and constants for the CORDIC vectoring arbiter slice.
//   CORDIC_W   : default operand/result width of the vectoring core
//   CORDIC_LAT : default pipeline depth of the vectoring core
//   req_id_t   : requester index, sized for the largest supported N_REQ (8)
//   tag_t      : {valid, id} tag that travels alongside the core pipeline
package cordic_vec_arb_pkg;

  localparam int CORDIC_W   = 16;
  localparam int CORDIC_LAT = 16;
  localparam int N_REQ_MAX  = 8;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/cordic_vec_arb_if.sv
// Requester-side bundle of the CORDIC vectoring arbiter.
//   req_valid/req_ready : per-requester offer and one-hot grant
//   req_a/req_b         : packed operands, slice i = [i*W +: W]
//   res_valid           : one-hot result strobe, no backpressure
//   res_r/res_ang       : result magnitude and angle
// master = requester side, slave = arbiter side.
interface cordic_vec_arb_if #(
  parameter int N_REQ = 2,
  parameter int W     = 16
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   res_valid;
  logic [W-1:0]       res_r;
  logic [W-1:0]       res_ang;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_r, res_ang
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_r, res_ang
  );

endinterface

// File: rtl/cordic_vec_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible : requesters allowed to win this cycle
//   ptr      : highest-priority index (register kept by the parent)
//   grant    : one-hot, first eligible index at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    // Walk from the farthest index back to ptr so the closest eligible
    // requester is the last (and therefore winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_vec_arb.sv
// Shares one pipelined CORDIC vectoring core between N_REQ requesters.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : requester handshake, operands and tagged results
//   core_a0/core_b0  : registered operands to the core input stage
//   core_r/core_ang  : core outputs, passed straight through to the results
//   busy             : an operation is in the issue register or tag pipeline
// A {valid,id} tag rides alongside the fixed-latency core; when it leaves the
// last stage it selects which requester sees the core output that cycle.
module cordic_vec_arb
  import cordic_vec_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = CORDIC_W,
  parameter int LATENCY = CORDIC_LAT,
  parameter int MAX_OUT = 4
) (
  input  logic           clk,
  input  logic           rst,
  cordic_vec_arb_if.slave bus,
  output logic [W-1:0]   core_a0,
  output logic [W-1:0]   core_b0,
  input  logic [W-1:0]   core_r,
  input  logic [W-1:0]   core_ang,
  output logic           busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    ptr_next;
  logic [CW-1:0]    out_cnt [N_REQ];
  tag_t             issue_tag;
  tag_t             tag_pipe [LATENCY];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] retire;
  req_id_t          grant_id;
  logic [W-1:0]     grant_a;
  logic [W-1:0]     grant_b;

  // Ready is held low during reset so nothing is accepted on the clearing edge.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (out_cnt[i] < CW'(MAX_OUT)) && !rst;
    end
  end

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant)
  );

  always_comb begin
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_id = req_id_t'(i);
        grant_a  = bus.req_a[i*W +: W];
        grant_b  = bus.req_b[i*W +: W];
      end
    end
  end

  assign ptr_next = (int'(grant_id) == N_REQ - 1) ? '0 : PW'(int'(grant_id) + 1);

  // Retire decode from the tag leaving the last stage, aligned with core_r/core_ang.
  always_comb begin
    retire = '0;
    for (int i = 0; i < N_REQ; i++) begin
      retire[i] = tag_pipe[LATENCY-1].valid && (tag_pipe[LATENCY-1].id == req_id_t'(i)) && !rst;
    end
  end

  always_comb begin
    busy = issue_tag.valid;
    for (int s = 0; s < LATENCY; s++) begin
      busy = busy | tag_pipe[s].valid;
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = retire;
  assign bus.res_r     = core_r;
  assign bus.res_ang   = core_ang;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what makes the shift register shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the tags are cleared; the core's data pipeline has no reset
      // and its stale contents are harmless because no valid tag accompanies them.
      rr_ptr    <= '0;
      core_a0   <= '0;
      core_b0   <= '0;
      issue_tag <= '0;
      for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
      for (int i = 0; i < N_REQ; i++)   out_cnt[i]  <= '0;
    end else begin
      if (|grant) begin
        core_a0   <= grant_a;
        core_b0   <= grant_b;
        issue_tag <= '{valid: 1'b1, id: grant_id};
        rr_ptr    <= ptr_next;
      end else begin
        core_a0   <= '0;
        core_b0   <= '0;
        issue_tag <= '0;
      end

      tag_pipe[0] <= issue_tag;
      for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];

      // Accept and retire on the same edge cancel out.
      for (int i = 0; i < N_REQ; i++) begin
        case ({grant[i], retire[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + CW'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CW'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

endmodule
